// File: rtl/line_decoder.sv
// rtl/line_decoder.sv - registered binary-to-one-hot decoder with enable and out-of-range flag
// Optional macro LINE_DECODER_ERRCNT_EN adds err_cnt, a saturating count of err pulses.
module line_decoder #(
  parameter int SEL_W = 2,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] x,
  input  logic             enable,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             err
`ifdef LINE_DECODER_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  // Reject output widths that cannot be addressed by the select code.
  if (OUT_W < 1 || OUT_W > (1 << SEL_W)) begin : g_bad_param
    $error("line_decoder: OUT_W must be in 1 .. 2**SEL_W");
  end

  logic [OUT_W-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [31:0]      x_ext;
  logic             in_range;

  // Zero-extend x so the range check never depends on SEL_W truncation.
  assign x_ext    = 32'(x);
  assign in_range = (x_ext < 32'(OUT_W));

  // Next-state decode; enable gates x entirely so unknowns on x stay out of y.
  always_comb begin
    y_d     = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (enable) begin
      if (in_range) begin
        y_d     = OUT_W'(1) << x;
        valid_d = 1'b1;
      end else begin
        err_d   = 1'b1;
      end
    end
  end

  // Output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign err   = err_q;

`ifdef LINE_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count each edge that loads err=1, holding at the maximum value.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_line_decoder.sv
// tb/tb_line_decoder.sv - directed self-checking bench for line_decoder (2/4 and 3/5 configurations)
module tb_line_decoder;

  logic       clk;
  logic       rst;
  logic [1:0] x_a;
  logic       en_a;
  logic [3:0] y_a;
  logic       valid_a;
  logic       err_a;
  logic [2:0] x_b;
  logic       en_b;
  logic [4:0] y_b;
  logic       valid_b;
  logic       err_b;
`ifdef LINE_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_a;
  logic [7:0] err_cnt_b;
`endif

  int checks;
  int fails;

  line_decoder #(.SEL_W(2), .OUT_W(4)) dut_a (
    .clk(clk), .rst(rst), .x(x_a), .enable(en_a),
    .y(y_a), .valid(valid_a), .err(err_a)
`ifdef LINE_DECODER_ERRCNT_EN
    , .err_cnt(err_cnt_a)
`endif
  );

  line_decoder #(.SEL_W(3), .OUT_W(5)) dut_b (
    .clk(clk), .rst(rst), .x(x_b), .enable(en_b),
    .y(y_b), .valid(valid_b), .err(err_b)
`ifdef LINE_DECODER_ERRCNT_EN
    , .err_cnt(err_cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; x_a = 2'b00; en_a = 1'b0; x_b = 3'b000; en_b = 1'b0;
    tick();
    tick();
    checks++;
    if (y_a !== 4'b0000 || valid_a !== 1'b0 || err_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: y=%b valid=%b err=%b expected 0000 0 0", y_a, valid_a, err_a);
    end
    checks++;
    if (y_b !== 5'b00000 || valid_b !== 1'b0 || err_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: y=%b valid=%b err=%b expected 00000 0 0", y_b, valid_b, err_b);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (y_a !== 4'b0000 || valid_a !== 1'b0 || err_a !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: y=%b valid=%b err=%b expected 0000 0 0", y_a, valid_a, err_a);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_y [4];
    exp_y[0] = 4'b0001; exp_y[1] = 4'b0010; exp_y[2] = 4'b0100; exp_y[3] = 4'b1000;
    en_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_a = 2'(i);
      tick();
      checks++;
      if (y_a !== exp_y[i] || valid_a !== 1'b1 || err_a !== 1'b0) begin
        fails++;
        $display("FAIL sweep x=%0d: y=%b valid=%b err=%b expected %b 1 0", i, y_a, valid_a, err_a, exp_y[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    en_a = 1'b1; x_a = 2'd3;
    tick();
    checks++;
    if (y_a !== 4'b1000 || valid_a !== 1'b1) begin
      fails++;
      $display("FAIL enable_drop_on: y=%b valid=%b expected 1000 1", y_a, valid_a);
    end
    en_a = 1'b0;
    tick();
    checks++;
    if (y_a !== 4'b0000 || valid_a !== 1'b0 || err_a !== 1'b0) begin
      fails++;
      $display("FAIL enable_drop_off: y=%b valid=%b err=%b expected 0000 0 0", y_a, valid_a, err_a);
    end
  endtask

  task automatic test_x_disabled();
    en_a = 1'b0; x_a = 2'bxx;
    tick();
    checks++;
    if (y_a !== 4'b0000 || valid_a !== 1'b0 || err_a !== 1'b0) begin
      fails++;
      $display("FAIL x_disabled: y=%b valid=%b err=%b expected 0000 0 0", y_a, valid_a, err_a);
    end
    en_a = 1'b1; x_a = 2'd1;
    tick();
    checks++;
    if (y_a !== 4'b0010 || valid_a !== 1'b1) begin
      fails++;
      $display("FAIL x_reenable: y=%b valid=%b expected 0010 1", y_a, valid_a);
    end
  endtask

  task automatic test_out_of_range();
    en_b = 1'b1; x_b = 3'd5;
    tick();
    checks++;
    if (y_b !== 5'b00000 || valid_b !== 1'b0 || err_b !== 1'b1) begin
      fails++;
      $display("FAIL oor_x5: y=%b valid=%b err=%b expected 00000 0 1", y_b, valid_b, err_b);
    end
    x_b = 3'd7;
    tick();
    checks++;
    if (y_b !== 5'b00000 || valid_b !== 1'b0 || err_b !== 1'b1) begin
      fails++;
      $display("FAIL oor_x7: y=%b valid=%b err=%b expected 00000 0 1", y_b, valid_b, err_b);
    end
    x_b = 3'd4;
    tick();
    checks++;
    if (y_b !== 5'b10000 || valid_b !== 1'b1 || err_b !== 1'b0) begin
      fails++;
      $display("FAIL oor_x4: y=%b valid=%b err=%b expected 10000 1 0", y_b, valid_b, err_b);
    end
    x_b = 3'd0;
    tick();
    checks++;
    if (y_b !== 5'b00001 || err_b !== 1'b0) begin
      fails++;
      $display("FAIL oor_x0: y=%b err=%b expected 00001 0", y_b, err_b);
    end
`ifdef LINE_DECODER_ERRCNT_EN
    checks++;
    if (err_cnt_b !== 8'd2) begin
      fails++;
      $display("FAIL err_cnt_two: err_cnt=%0d expected 2", err_cnt_b);
    end
`endif
    en_b = 1'b0;
  endtask

  task automatic test_mid_reset();
    en_a = 1'b1; x_a = 2'd2;
    tick();
    checks++;
    if (y_a !== 4'b0100) begin
      fails++;
      $display("FAIL mid_reset_pre: y=%b expected 0100", y_a);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (y_a !== 4'b0000 || valid_a !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_during: y=%b valid=%b expected 0000 0", y_a, valid_a);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (y_a !== 4'b0100 || valid_a !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_resume: y=%b valid=%b expected 0100 1", y_a, valid_a);
    end
  endtask

`ifdef LINE_DECODER_ERRCNT_EN
  task automatic test_saturation();
    en_b = 1'b1; x_b = 3'd6;
    for (int i = 0; i < 300; i++) begin
      tick();
    end
    checks++;
    if (err_cnt_b !== 8'd255 || err_b !== 1'b1) begin
      fails++;
      $display("FAIL sat_reach: err_cnt=%0d err=%b expected 255 1", err_cnt_b, err_b);
    end
    tick();
    checks++;
    if (err_cnt_b !== 8'd255) begin
      fails++;
      $display("FAIL sat_hold: err_cnt=%0d expected 255", err_cnt_b);
    end
    checks++;
    if (err_cnt_a !== 8'd0) begin
      fails++;
      $display("FAIL cnt_full_range: err_cnt=%0d expected 0", err_cnt_a);
    end
    en_b = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (err_cnt_b !== 8'd0) begin
      fails++;
      $display("FAIL sat_clear: err_cnt=%0d expected 0", err_cnt_b);
    end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_sweep();
    test_enable_drop();
    test_x_disabled();
    test_out_of_range();
    test_mid_reset();
`ifdef LINE_DECODER_ERRCNT_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
